// File: rtl/load_unit.sv
// Load unit: word-aligned memory read, lane extraction and sign/zero extension.
// Optional WAIT watchdog enabled by defining LOAD_UNIT_TIMEOUT_EN.
module load_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [2:0]            loadType,
    input  logic [4:0]            reqRd,
    output logic                  memRead,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [31:0]           memReadData,
    input  logic                  memReadValid,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [31:0]           respData,
    output logic [4:0]            respRd,
    output logic                  respError
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} stateT;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    stateT      state;
    logic [1:0] offsetQ;
    logic [2:0] typeQ;
    logic       badReq;
    logic [7:0] byteSel;
    logic [15:0] halfSel;
    logic [31:0] extData;

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;
`endif

    assign reqReady = (state == S_IDLE);

    // Unknown funct3 codes and misaligned halfword/word accesses never reach memory.
    always_comb begin
        badReq = 1'b1;
        case (loadType)
            LB, LBU: badReq = 1'b0;
            LH, LHU: badReq = reqAddr[0];
            LW:      badReq = (reqAddr[1:0] != 2'b00);
            default: badReq = 1'b1;
        endcase
    end

    always_comb begin
        byteSel = memReadData[{offsetQ, 3'b000} +: 8];
        halfSel = offsetQ[1] ? memReadData[31:16] : memReadData[15:0];
        extData = memReadData;
        case (typeQ)
            LB:      extData = {{24{byteSel[7]}}, byteSel};
            LBU:     extData = {24'd0, byteSel};
            LH:      extData = {{16{halfSel[15]}}, halfSel};
            LHU:     extData = {16'd0, halfSel};
            default: extData = memReadData;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            memRead   <= 1'b0;
            memAddr   <= '0;
            respValid <= 1'b0;
            respData  <= '0;
            respRd    <= '0;
            respError <= 1'b0;
            offsetQ   <= '0;
            typeQ     <= '0;
`ifdef LOAD_UNIT_TIMEOUT_EN
            waitCnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (reqValid) begin
                        offsetQ <= reqAddr[1:0];
                        typeQ   <= loadType;
                        respRd  <= reqRd;
                        if (badReq) begin
                            state     <= S_RESP;
                            respValid <= 1'b1;
                            respError <= 1'b1;
                            respData  <= '0;
                        end else begin
                            state   <= S_WAIT;
                            memRead <= 1'b1;
                            memAddr <= {reqAddr[ADDR_WIDTH-1:2], 2'b00};
`ifdef LOAD_UNIT_TIMEOUT_EN
                            waitCnt <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    // Data arriving on the limit edge takes priority over the watchdog.
                    if (memReadValid) begin
                        state     <= S_RESP;
                        memRead   <= 1'b0;
                        respValid <= 1'b1;
                        respError <= 1'b0;
                        respData  <= extData;
`ifdef LOAD_UNIT_TIMEOUT_EN
                    end else if (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= S_RESP;
                        memRead   <= 1'b0;
                        respValid <= 1'b1;
                        respError <= 1'b1;
                        respData  <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (respReady) begin
                        state     <= S_IDLE;
                        respValid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: table of loads, error paths, stalls, reset abort, watchdog.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [31:0] reqAddr = '0;
    logic [2:0]  loadType = '0;
    logic [4:0]  reqRd = '0;
    logic        memRead;
    logic [31:0] memAddr;
    logic [31:0] memReadData = '0;
    logic        memReadValid = 1'b0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] respData;
    logic [4:0]  respRd;
    logic        respError;

    localparam int TO = 16;

    load_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .loadType(loadType), .reqRd(reqRd),
        .memRead(memRead), .memAddr(memAddr),
        .memReadData(memReadData), .memReadValid(memReadValid),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .respRd(respRd), .respError(respError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  rd;
    } expT;

    expT         sb[$];
    int          errCnt = 0;
    int          chkCnt = 0;
    int          memDelay = 0;
    int          memCnt = 0;
    bit          memOn = 1'b1;
    bit          staleMode = 1'b0;
    logic [31:0] expMemAddr = '0;
    int          addrBad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h1000: memWord = 32'hDEADBEEF;
            32'h2000: memWord = 32'h80017F7E;
            default:  memWord = ~a;
        endcase
    endfunction

    // Memory responds memDelay cycles after memRead rises; address must stay put.
    always @(negedge clk) begin
        if (staleMode) begin
            memReadValid = 1'b1;
            memReadData  = 32'h12345678;
        end else if (memRead && memOn) begin
            if (memCnt >= memDelay) begin
                memReadValid = 1'b1;
                memReadData  = memWord(memAddr);
            end else begin
                memReadValid = 1'b0;
                memCnt++;
            end
        end else begin
            memReadValid = 1'b0;
            if (!memRead) memCnt = 0;
        end
        if (memRead && memAddr !== expMemAddr) addrBad++;
    end

    task automatic issue(input logic [31:0] addr, input logic [2:0] lt, input logic [4:0] rd);
        expMemAddr = {addr[31:2], 2'b00};
        @(negedge clk);
        reqValid = 1'b1; reqAddr = addr; loadType = lt; reqRd = rd;
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    task automatic runLoad(input logic [31:0] addr, input logic [2:0] lt, input logic [4:0] rd,
                           input logic [31:0] expData, input logic expErr,
                           input int dly, input int rdyDly, input int expLat);
        expT e;
        int lat, holdBad, readBad;
        logic [31:0] hd;
        e.data = expData; e.err = expErr; e.rd = rd;
        sb.push_back(e);
        memDelay = dly; addrBad = 0; lat = 0; holdBad = 0; readBad = 0;
        issue(addr, lt, rd);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (expErr && memRead) readBad++;
            if (reqReady) holdBad++;
            if (respValid) break;
            lat++;
        end
        chk("latency", lat, expLat);
        hd = respData;
        for (int i = 0; i < rdyDly; i++) begin
            @(negedge clk);
            if (!respValid || respData !== hd || reqReady) holdBad++;
            if (expErr && memRead) readBad++;
        end
        e = sb.pop_front();
        chk("respData", respData, e.data);
        chk("respError", respError, e.err);
        chk("respRd", respRd, e.rd);
        chk("busyHold", holdBad, 0);
        chk("memAddr", addrBad, 0);
        chk("memReadIdle", memRead, 0);
        if (expErr) chk("memReadOnErr", readBad, 0);
        respReady = 1'b1;
        @(posedge clk);
        #1 respReady = 1'b0;
        chk("respValidDrop", respValid, 0);
        chk("reqReadyBack", reqReady, 1);
    endtask

    task automatic checkResetOuts(input string tag);
        chk({tag, "Ctl"}, {memRead, respValid, respError, respRd}, 0);
        chk({tag, "Addr"}, memAddr, 0);
        chk({tag, "Data"}, respData, 0);
        chk({tag, "Ready"}, reqReady, 1);
    endtask

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        checkResetOuts("rst");
        reset_n = 1'b1;

        // addr, type, rd, expected data, err, memDelay, readyDelay, latency
        runLoad(32'h1003, 3'b000, 5'd1,  32'hFFFFFFDE, 1'b0, 0, 0, 1);
        runLoad(32'h1000, 3'b100, 5'd2,  32'h000000EF, 1'b0, 0, 0, 1);
        runLoad(32'h1002, 3'b001, 5'd3,  32'hFFFFDEAD, 1'b0, 0, 0, 1);
        runLoad(32'h1000, 3'b101, 5'd4,  32'h0000BEEF, 1'b0, 0, 0, 1);
        runLoad(32'h1000, 3'b010, 5'd7,  32'hDEADBEEF, 1'b0, 0, 0, 1);
        runLoad(32'h2001, 3'b000, 5'd8,  32'h0000007F, 1'b0, 0, 0, 1);
        runLoad(32'h2003, 3'b000, 5'd9,  32'hFFFFFF80, 1'b0, 0, 0, 1);
        runLoad(32'h2003, 3'b100, 5'd10, 32'h00000080, 1'b0, 0, 0, 1);
        runLoad(32'h2002, 3'b001, 5'd11, 32'hFFFF8001, 1'b0, 0, 0, 1);
        runLoad(32'h2000, 3'b001, 5'd12, 32'h00007F7E, 1'b0, 0, 0, 1);
        runLoad(32'h2002, 3'b101, 5'd13, 32'h00008001, 1'b0, 0, 0, 1);
        runLoad(32'h2002, 3'b100, 5'd14, 32'h00000001, 1'b0, 0, 0, 1);
        // error path: no memory access, response one edge after acceptance
        runLoad(32'h1001, 3'b010, 5'd15, 32'h0, 1'b1, 0, 0, 0);
        runLoad(32'h1000, 3'b011, 5'd16, 32'h0, 1'b1, 0, 0, 0);
        runLoad(32'h1002, 3'b010, 5'd17, 32'h0, 1'b1, 0, 0, 0);
        runLoad(32'h1001, 3'b001, 5'd18, 32'h0, 1'b1, 0, 0, 0);
        runLoad(32'h1003, 3'b101, 5'd19, 32'h0, 1'b1, 0, 0, 0);
        runLoad(32'h1000, 3'b111, 5'd20, 32'h0, 1'b1, 0, 2, 0);
        // slow memory and stalled writeback
        runLoad(32'h1000, 3'b010, 5'd21, 32'hDEADBEEF, 1'b0, 5, 3, 6);
        runLoad(32'h2001, 3'b000, 5'd22, 32'h0000007F, 1'b0, 2, 1, 3);

        // reset mid-WAIT, then a stale response that must be ignored
        memOn = 1'b0;
        issue(32'h1003, 3'b000, 5'd9);
        repeat (3) @(negedge clk);
        chk("waitRead", memRead, 1);
        reset_n = 1'b0;
        #1 checkResetOuts("midRst");
        @(negedge clk);
        reset_n = 1'b1;
        staleMode = 1'b1; memOn = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (respValid || memRead || !reqReady) cnt++;
        end
        staleMode = 1'b0;
        chk("staleIgnored", cnt, 0);
        runLoad(32'h1000, 3'b010, 5'd23, 32'hDEADBEEF, 1'b0, 0, 0, 1);

        // memory never answers
        memOn = 1'b0;
`ifdef LOAD_UNIT_TIMEOUT_EN
        runLoad(32'h1000, 3'b010, 5'd24, 32'h0, 1'b1, 0, 1, TO);
`else
        issue(32'h1000, 3'b010, 5'd24);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (respValid) cnt++;
        end
        chk("noTimeout", cnt, 0);
        chk("stillReading", memRead, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        memOn = 1'b1;
        runLoad(32'h1002, 3'b101, 5'd25, 32'h0000DEAD, 1'b0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
